// File: rtl/multi_sample_ce_generator.sv
// Multi-channel sample clock-enable generator with a shared ns->ticks restoring divider.
// Latency: config accept to terminal commit is CNT_W+1 cycles; ce is registered.
// Backpressure: cfg_ready is low while a divide/commit is in flight; requester holds cfg_valid.
module multi_sample_ce_generator #(
    parameter  int NUM_CH        = 4,
    parameter  int CNT_W         = 32,
    parameter  int CLK_PERIOD_NS = 10,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period_ns,
    output logic              busy,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce
);

    localparam int BC_W = $clog2(CNT_W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]       state;
    logic [CH_W-1:0]  lat_ch;
    logic [CNT_W-1:0] lat_period;
    logic [CNT_W-1:0] dvd;        // dividend, shifted out MSB first
    logic [CNT_W-1:0] quo;        // quotient, shifted in LSB side
    logic [CNT_W:0]   rem;        // partial remainder, one bit wider than the operands
    logic [BC_W-1:0]  bit_cnt;

    logic [CNT_W-1:0] terminal [NUM_CH];
    logic [CNT_W-1:0] cnt      [NUM_CH];

    logic             accept;
    logic             ch_oor;
    logic             commit;
    logic [CNT_W:0]   trial;
    logic [CNT_W:0]   divisor;
    logic             q_bit;
    logic [CNT_W-1:0] new_term;

    assign cfg_ready = rst && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign commit    = (state == S_COMMIT);

    // With a power-of-two channel count the index can never be out of range.
    assign ch_oor  = {1'b0, cfg_ch} >= (CH_W + 1)'(NUM_CH);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign divisor = (CNT_W + 1)'(CLK_PERIOD_NS);
    assign trial   = (rem << 1) | {{CNT_W{1'b0}}, dvd[CNT_W-1]};
    assign q_bit   = (trial >= divisor);

    // Zero period stops the channel; sub-tick periods clamp to one tick (ce held high).
    assign new_term = (lat_period == '0) ? '0 :
                      (quo == '0)        ? CNT_W'(1) : quo;

    // Config FSM and shared divider datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            lat_ch     <= '0;
            lat_period <= '0;
            dvd        <= '0;
            quo        <= '0;
            rem        <= '0;
            bit_cnt    <= '0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (ch_oor) begin
                            cfg_err <= 1'b1;
                        end else begin
                            lat_ch     <= cfg_ch;
                            lat_period <= cfg_period_ns;
                            dvd        <= cfg_period_ns;
                            quo        <= '0;
                            rem        <= '0;
                            bit_cnt    <= '0;
                            state      <= S_DIVIDE;
                        end
                    end
                end
                S_DIVIDE: begin
                    rem     <= q_bit ? (trial - divisor) : trial;
                    quo     <= (quo << 1) | CNT_W'(q_bit);
                    dvd     <= dvd << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BC_W'(CNT_W - 1)) begin
                        state <= S_COMMIT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-channel terminal registers and free-running phase counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                terminal[i] <= '0;
                cnt[i]      <= '0;
            end
            ce <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (commit && (lat_ch == CH_W'(i))) begin
                    terminal[i] <= new_term;
                    cnt[i]      <= '0;
                    ce[i]       <= 1'b0;
                end else if (!ch_enable[i] || (terminal[i] == '0)) begin
                    cnt[i] <= '0;
                    ce[i]  <= 1'b0;
                end else if (cnt[i] == terminal[i] - CNT_W'(1)) begin
                    cnt[i] <= '0;
                    ce[i]  <= 1'b1;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                    ce[i]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_sample_ce_generator.sv
// Bench for multi_sample_ce_generator: directed scenarios plus randomized configs.
// Expected ce/ready/busy/err come from a tick-arithmetic model of the channel rules.
// A second 3-channel instance exercises the out-of-range channel index.
module tb_multi_sample_ce_generator;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int CLK_NS = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_enable;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_period_ns;
    logic              busy;
    logic              cfg_err;
    logic [NUM_CH-1:0] ce;

    logic [2:0] ch_enable3;
    logic       cfg_valid3;
    logic       cfg_ready3;
    logic [1:0] cfg_ch3;
    logic [7:0] cfg_period3;
    logic       busy3;
    logic       cfg_err3;
    logic [2:0] ce3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_sample_ce_generator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CLK_PERIOD_NS(CLK_NS)) dut (
        .clk(clk), .rst(rst), .ch_enable(ch_enable), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_period_ns(cfg_period_ns),
        .busy(busy), .cfg_err(cfg_err), .ce(ce)
    );

    multi_sample_ce_generator #(.NUM_CH(3), .CNT_W(8), .CLK_PERIOD_NS(CLK_NS)) dut3 (
        .clk(clk), .rst(rst), .ch_enable(ch_enable3), .cfg_valid(cfg_valid3),
        .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3), .cfg_period_ns(cfg_period3),
        .busy(busy3), .cfg_err(cfg_err3), .ce(ce3)
    );

    // ---------------- reference model ----------------
    // Each channel remembers the edge at which its phase last restarted;
    // it pulses whenever the edges elapsed since then are a multiple of N.
    longint      cyc = 0;
    int unsigned m_term  [NUM_CH];
    longint      m_start [NUM_CH];
    logic [NUM_CH-1:0] m_ce = '0;
    bit          m_busy = 1'b0;
    bit          m_err  = 1'b0;
    int          m_ch;
    int unsigned m_per;
    longint      m_commit;

    always @(posedge clk) begin : model
        bit          commit_now;
        int unsigned q;
        if (!rst) begin
            m_busy = 1'b0;
            m_err  = 1'b0;
            m_ce   = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_term[i]  = 0;
                m_start[i] = cyc;
            end
        end else begin
            commit_now = m_busy && (cyc == m_commit);
            m_err = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if ((commit_now && m_ch == i) || !ch_enable[i] || m_term[i] == 0) begin
                    m_start[i] = cyc;
                    m_ce[i]    = 1'b0;
                end else begin
                    m_ce[i] = ((cyc - m_start[i]) % longint'(m_term[i])) == 0;
                end
            end
            if (commit_now) begin
                q = m_per / CLK_NS;
                m_term[m_ch] = (m_per == 0) ? 0 : ((q == 0) ? 1 : q);
                m_busy = 1'b0;
            end else if (!m_busy && cfg_valid) begin
                if (int'(cfg_ch) >= NUM_CH) begin
                    m_err = 1'b1;
                end else begin
                    m_busy   = 1'b1;
                    m_ch     = int'(cfg_ch);
                    m_per    = cfg_period_ns;
                    m_commit = cyc + CNT_W + 1;
                end
            end
        end
        cyc++;
    end

    // Drive one config request once the model says the block is idle (drive only).
    task automatic send_cfg(input int ch, input int unsigned per);
        for (int k = 0; k < 100 && m_busy; k++) @(negedge clk);
        if (m_busy) begin
            checks++;
            failures++;
            $display("FAIL send_cfg_wait: busy still %0b after 100 cycles, required 0", m_busy);
        end
        cfg_valid     = 1'b1;
        cfg_ch        = 2'(ch);
        cfg_period_ns = per;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ch_enable = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period_ns = '0;
        ch_enable3 = '0; cfg_valid3 = 1'b0; cfg_ch3 = '0; cfg_period3 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ce, cfg_ready, busy, cfg_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state: ce/rdy/busy/err=%b required 0000000", {ce, cfg_ready, busy, cfg_err});
        end
        rst = 1'b1;
        ch_enable = 4'hF;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: cfg_ready=%b required 1", cfg_ready);
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++;
            if (ce !== 4'h0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle c=%0d: ce=%h rdy=%b busy=%b required ce=0 rdy=1 busy=0", c, ce, cfg_ready, busy);
            end
        end
    endtask

    task automatic test_program_ch0();
        int low_cnt;
        int pulses;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_period_ns = 100;
        @(negedge clk);
        cfg_valid = 1'b0;
        low_cnt = 0;
        while (cfg_ready === 1'b0 && low_cnt < 100) begin
            low_cnt++;
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL ch0_busy cycle=%0d: busy=%b required 1", low_cnt, busy);
            end
            @(negedge clk);
        end
        checks++;
        if (low_cnt != CNT_W + 1) begin
            failures++;
            $display("FAIL ch0_ready_low: low cycles=%0d required %0d", low_cnt, CNT_W + 1);
        end
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            pulses += int'(ce[0]);
            checks++;
            if ({ce, cfg_ready, busy, cfg_err} !== {m_ce, rst && !m_busy, m_busy, m_err} || ce[3:1] !== 3'b0) begin
                failures++;
                $display("FAIL ch0_run c=%0d: ce/rdy/busy/err=%b required %b", c,
                         {ce, cfg_ready, busy, cfg_err}, {m_ce, rst && !m_busy, m_busy, m_err});
            end
        end
        checks++;
        if (pulses != 6) begin
            failures++;
            $display("FAIL ch0_pulse_count: pulses=%0d required 6", pulses);
        end
    endtask

    task automatic test_multi();
        send_cfg(1, 25);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if ({ce, cfg_ready, busy, cfg_err} !== {m_ce, rst && !m_busy, m_busy, m_err}) begin
                failures++;
                $display("FAIL multi_ch1 c=%0d: ce/rdy/busy/err=%b required %b", c,
                         {ce, cfg_ready, busy, cfg_err}, {m_ce, rst && !m_busy, m_busy, m_err});
            end
        end
        send_cfg(2, 7);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            checks++;
            if ({ce, cfg_ready, busy, cfg_err} !== {m_ce, rst && !m_busy, m_busy, m_err}) begin
                failures++;
                $display("FAIL multi_ch2 c=%0d: ce/rdy/busy/err=%b required %b", c,
                         {ce, cfg_ready, busy, cfg_err}, {m_ce, rst && !m_busy, m_busy, m_err});
            end
        end
        checks++;
        if (ce[2] !== 1'b1) begin
            failures++;
            $display("FAIL multi_ch2_steady: ce[2]=%b required 1", ce[2]);
        end
    endtask

    task automatic test_zero_period();
        int seen;
        send_cfg(3, 0);
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            seen += int'(ce[3]);
            checks++;
            if ({ce, cfg_ready, busy, cfg_err} !== {m_ce, rst && !m_busy, m_busy, m_err}) begin
                failures++;
                $display("FAIL zero_run c=%0d: ce/rdy/busy/err=%b required %b", c,
                         {ce, cfg_ready, busy, cfg_err}, {m_ce, rst && !m_busy, m_busy, m_err});
            end
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL zero_ce3: ce[3] pulses=%0d required 0", seen);
        end
        send_cfg(3, 40);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            checks++;
            if ({ce, cfg_ready, busy, cfg_err} !== {m_ce, rst && !m_busy, m_busy, m_err}) begin
                failures++;
                $display("FAIL ch3_40ns c=%0d: ce/rdy/busy/err=%b required %b", c,
                         {ce, cfg_ready, busy, cfg_err}, {m_ce, rst && !m_busy, m_busy, m_err});
            end
        end
    endtask

    task automatic test_enable_drop();
        int gap;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        ch_enable[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ce[0] !== 1'b0 || ce !== m_ce) begin
                failures++;
                $display("FAIL en_low c=%0d: ce=%h required %h", c, ce, m_ce);
            end
        end
        ch_enable[0] = 1'b1;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            checks++;
            if (ce !== m_ce) begin
                failures++;
                $display("FAIL en_resume c=%0d: ce=%h required %h", gap, ce, m_ce);
            end
        end while (ce[0] !== 1'b1 && gap < 50);
        checks++;
        if (gap != 10) begin
            failures++;
            $display("FAIL en_first_pulse: cycles after re-enable=%0d required 10", gap);
        end
    endtask

    task automatic test_cfg_err();
        ch_enable3 = 3'b111;
        @(negedge clk);
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_period3 = 8'd50;
        @(negedge clk);
        cfg_valid3 = 1'b0;
        checks++;
        if ({cfg_err3, cfg_ready3, busy3} !== 3'b110) begin
            failures++;
            $display("FAIL err_pulse: err/rdy/busy=%b required 110", {cfg_err3, cfg_ready3, busy3});
        end
        @(negedge clk);
        checks++;
        if (cfg_err3 !== 1'b0) begin
            failures++;
            $display("FAIL err_one_cycle: cfg_err=%b required 0", cfg_err3);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (ce3 !== 3'b0 || busy3 !== 1'b0 || cfg_ready3 !== 1'b1) begin
                failures++;
                $display("FAIL err_no_change c=%0d: ce=%b busy=%b rdy=%b required 000 0 1", c, ce3, busy3, cfg_ready3);
            end
        end
    endtask

    task automatic test_reset_mid_divide();
        send_cfg(1, 50);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ce, cfg_ready, busy} !== 6'b0) begin
            failures++;
            $display("FAIL rst_divide_hold: ce/rdy/busy=%b required 000000", {ce, cfg_ready, busy});
        end
        rst = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if (ce !== 4'h0 || {cfg_ready, busy, cfg_err} !== {rst && !m_busy, m_busy, m_err}) begin
                failures++;
                $display("FAIL rst_divide_after c=%0d: ce=%h rdy/busy/err=%b required ce=0 %b", c, ce,
                         {cfg_ready, busy, cfg_err}, {rst && !m_busy, m_busy, m_err});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if ({ce, cfg_ready, busy, cfg_err} !== {m_ce, rst && !m_busy, m_busy, m_err}) begin
                failures++;
                $display("FAIL random c=%0d: ce/rdy/busy/err=%b required %b", c,
                         {ce, cfg_ready, busy, cfg_err}, {m_ce, rst && !m_busy, m_busy, m_err});
            end
            // Pulses of cfg_valid land both while idle (accepted) and busy (ignored).
            if (cfg_valid) begin
                cfg_valid = 1'b0;
            end else if ($urandom_range(0, 11) == 0) begin
                cfg_valid     = 1'b1;
                cfg_ch        = 2'($urandom_range(0, 3));
                cfg_period_ns = $urandom_range(0, 70);
            end
            if ($urandom_range(0, 19) == 0) begin
                ch_enable[$urandom_range(0, 3)] ^= 1'b1;
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_program_ch0();
        test_multi();
        test_zero_period();
        test_enable_drop();
        test_cfg_err();
        test_reset_mid_divide();
        ch_enable = 4'hF;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
